// File: rtl/multdiv_unit_pkg.sv
// Execute-stage constants shared by the multiply/divide unit.
package multdiv_unit_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int unsigned MULT_ITERS = 16;
  localparam int unsigned DIV_ITERS  = 32;
  localparam logic [31:0] INT_MIN    = 32'h8000_0000;

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/multdiv_unit_booth.sv
// Radix-4 Booth recoder: maps a 3-bit multiplier group to partial-product controls.
module booth_recode (
  input  logic [2:0] i_group,
  output logic       o_zero,
  output logic       o_neg,
  output logic       o_dbl
);

  assign o_zero = (i_group == 3'b000) || (i_group == 3'b111);
  assign o_neg  = i_group[2] & ~(i_group[1] & i_group[0]);
  assign o_dbl  = (i_group == 3'b011) || (i_group == 3'b100);

endmodule

// File: rtl/multdiv_unit.sv
// Multi-cycle signed 32-bit multiply (radix-4 Booth) / divide (restoring) unit.
module multdiv_unit
  import multdiv_unit_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY
);

  state_t      r_state, w_next;
  logic [5:0]  r_cnt;
  logic [63:0] r_prod;
  logic        r_qm1;
  logic [31:0] r_mcand;
  logic [63:0] r_rq;
  logic [31:0] r_dvsr;
  logic        r_qneg, r_dovf;
  logic [31:0] r_result;
  logic        r_exc, r_rdy;

  logic        w_zero, w_neg, w_dbl;
  logic [33:0] w_mag, w_pp, w_hi;
  logic [63:0] w_prod_next;
  logic [32:0] w_diff;
  logic [63:0] w_rq_next;
  logic        w_mul_last, w_div_last, w_divz;

  booth_recode u_booth (
    .i_group (r_prod[2:0] == 3'b000 ? {r_prod[1:0], r_qm1} : {r_prod[1:0], r_qm1}),
    .o_zero  (w_zero),
    .o_neg   (w_neg),
    .o_dbl   (w_dbl)
  );

  // Multiplier bits sit in the low half of r_prod and shift out as the sum moves in.
  assign w_mag       = w_dbl ? {r_mcand[31], r_mcand, 1'b0} : {{2{r_mcand[31]}}, r_mcand};
  assign w_pp        = w_zero ? '0 : (w_neg ? (~w_mag + 34'd1) : w_mag);
  assign w_hi        = {{2{r_prod[63]}}, r_prod[63:32]} + w_pp;
  assign w_prod_next = {w_hi, r_prod[31:2]};

  // Shifted remainder is {r_rq[63:31]}; it never exceeds 32 significant bits.
  assign w_diff    = r_rq[63:31] - {1'b0, r_dvsr};
  assign w_rq_next = ~w_diff[32] ? {w_diff[31:0], r_rq[30:0], 1'b1} : {r_rq[62:0], 1'b0};

  assign w_mul_last = (r_state == S_MUL) && (r_cnt == 6'(MULT_ITERS - 1));
  assign w_div_last = (r_state == S_DIV) && (r_cnt == 6'(DIV_ITERS - 1));
  assign w_divz     = (data_operandB == '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_MUL:   if (w_mul_last) w_next = S_DONE;
      S_DIV:   if (w_div_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = r_state;
    endcase
    if (ctrl_MULT)     w_next = S_MUL;
    else if (ctrl_DIV) w_next = w_divz ? S_DONE : S_DIV;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_prod   <= '0;
      r_qm1    <= 1'b0;
      r_mcand  <= '0;
      r_rq     <= '0;
      r_dvsr   <= '0;
      r_qneg   <= 1'b0;
      r_dovf   <= 1'b0;
      r_result <= '0;
      r_exc    <= 1'b0;
      r_rdy    <= 1'b0;
    end else begin
      r_rdy <= 1'b0;
      if (ctrl_MULT) begin
        r_cnt   <= '0;
        r_prod  <= {32'd0, data_operandB};
        r_qm1   <= 1'b0;
        r_mcand <= data_operandA;
      end else if (ctrl_DIV) begin
        r_cnt  <= '0;
        r_rq   <= {32'd0, abs32(data_operandA)};
        r_dvsr <= abs32(data_operandB);
        r_qneg <= data_operandA[31] ^ data_operandB[31];
        r_dovf <= (data_operandA == INT_MIN) && (data_operandB == '1);
        if (w_divz) begin
          r_result <= '0;
          r_exc    <= 1'b1;
          r_rdy    <= 1'b1;
        end
      end else begin
        case (r_state)
          S_MUL: begin
            r_prod <= w_prod_next;
            r_qm1  <= r_prod[1];
            r_cnt  <= r_cnt + 6'd1;
            if (w_mul_last) begin
              r_cnt    <= '0;
              r_result <= w_prod_next[31:0];
              r_exc    <= (w_prod_next[63:32] != {32{w_prod_next[31]}});
              r_rdy    <= 1'b1;
            end
          end
          S_DIV: begin
            r_rq  <= w_rq_next;
            r_cnt <= r_cnt + 6'd1;
            if (w_div_last) begin
              r_cnt    <= '0;
              r_result <= r_qneg ? (~w_rq_next[31:0] + 32'd1) : w_rq_next[31:0];
              r_exc    <= r_dovf;
              r_rdy    <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign data_result    = r_result;
  assign data_exception = r_exc;
  assign data_resultRDY = r_rdy;

endmodule

// File: tb/tb_multdiv_unit.sv
// Self-checking bench for multdiv_unit: directed table, random ops vs. arithmetic model, corner sequences.
module tb_multdiv_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] data_operandA, data_operandB;
  logic        ctrl_MULT, ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY;

  int n_checks = 0;
  int n_errors = 0;

  multdiv_unit dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          m;
    bit          d;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    bit          exc;
    int          lat;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  // Arithmetic reference: plain signed math, no knowledge of the iteration scheme.
  function automatic void ref_op(input bit m, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output bit e, output int lat);
    longint p;
    int     ia, ib;
    ia = a;
    ib = b;
    if (m) begin
      p   = longint'(ia) * longint'(ib);
      r   = p[31:0];
      e   = (p != longint'(int'(p[31:0])));
      lat = 17;
    end else if (b == 32'd0) begin
      r = 32'd0; e = 1'b1; lat = 1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r = 32'h8000_0000; e = 1'b1; lat = 33;
    end else begin
      r = ia / ib; e = 1'b0; lat = 33;
    end
  endfunction

  task automatic pulse(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    ctrl_MULT = m; ctrl_DIV = d; data_operandA = a; data_operandB = b;
    @(negedge clock);
    ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    data_operandA = $urandom; data_operandB = $urandom;
  endtask

  // Called at the negedge of cycle 1 after the start pulse.
  task automatic wait_rdy(input int lat, input logic [31:0] er, input bit ee, input string nm);
    int n;
    logic [31:0] got;
    n = 1;
    while (!data_resultRDY && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk({nm, "_lat"}, n, lat);
    if (data_resultRDY) begin
      got = data_result;
      chk({nm, "_res"}, got, er);
      chk({nm, "_exc"}, {31'd0, data_exception}, {31'd0, ee});
      @(negedge clock);
      chk({nm, "_rdy1cyc"}, {31'd0, data_resultRDY}, 32'd0);
      chk({nm, "_hold"}, data_result, er);
    end
  endtask

  vec_t vecs[$];

  initial begin
    logic [31:0] a, b, er;
    bit          ee, m;
    int          lat, cnt, at;
    logic [31:0] rdy_res;

    vecs.push_back('{1, 0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 0, 17});
    vecs.push_back('{1, 0, 32'h0001_0000,  32'h0001_0000, 32'h0000_0000, 1, 17});
    vecs.push_back('{1, 0, 32'h7FFF_FFFF,  32'd1,         32'h7FFF_FFFF, 0, 17});
    vecs.push_back('{1, 0, 32'h8000_0000,  32'h8000_0000, 32'h0000_0000, 1, 17});
    vecs.push_back('{1, 0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0001, 0, 17});
    vecs.push_back('{1, 0, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1, 17});
    vecs.push_back('{0, 1, 32'hFFFF_FFEF,  32'd5,         32'hFFFF_FFFD, 0, 33});
    vecs.push_back('{0, 1, 32'd100,        32'hFFFF_FFF9, 32'hFFFF_FFF2, 0, 33});
    vecs.push_back('{0, 1, 32'hFFFF_FF9C,  32'd10,        32'hFFFF_FFF6, 0, 33});
    vecs.push_back('{0, 1, 32'd5,          32'd0,         32'h0000_0000, 1, 1});
    vecs.push_back('{0, 1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1, 33});
    vecs.push_back('{0, 1, 32'h8000_0000,  32'd1,         32'h8000_0000, 0, 33});
    vecs.push_back('{1, 1, 32'd12,         32'd4,         32'h0000_0030, 0, 17});

    reset = 1'b1; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    data_operandA = '0; data_operandB = '0;
    repeat (2) @(negedge clock);
    chk("reset_res", data_result, 32'd0);
    chk("reset_exc", {31'd0, data_exception}, 32'd0);
    chk("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      pulse(vecs[i].m, vecs[i].d, vecs[i].a, vecs[i].b);
      wait_rdy(vecs[i].lat, vecs[i].res, vecs[i].exc, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 40; i++) begin
      m = $urandom_range(0, 1);
      if ($urandom_range(0, 2) == 0) begin
        a = 32'($urandom_range(0, 2000)) - 32'd1000;
        b = 32'($urandom_range(0, 2000)) - 32'd1000;
      end else begin
        a = $urandom;
        b = (m || $urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 70000)) - 32'd35000;
      end
      if ($urandom_range(0, 9) == 0) b = 32'd0;
      ref_op(m, a, b, er, ee, lat);
      pulse(m, ~m, a, b);
      wait_rdy(lat, er, ee, $sformatf("rnd%0d", i));
    end

    // Reset mid-multiply: outputs must clear immediately and no strobe may follow.
    pulse(1, 0, 32'd7, 32'hFFFF_FFFD);
    wait_rdy(17, 32'hFFFF_FFEB, 0, "pre_reset");
    pulse(1, 0, 32'd1234, 32'd5678);
    repeat (7) @(negedge clock);
    reset = 1'b1;
    #1;
    chk("midrst_res", data_result, 32'd0);
    chk("midrst_exc", {31'd0, data_exception}, 32'd0);
    chk("midrst_rdy", {31'd0, data_resultRDY}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    cnt = 0;
    repeat (40) begin
      @(negedge clock);
      if (data_resultRDY) cnt++;
    end
    chk("midrst_norday", cnt, 0);

    // Divide aborted by a multiply pulse in cycle 10.
    pulse(0, 1, 32'd1000, 32'd3);
    repeat (8) @(negedge clock);
    @(negedge clock);
    ctrl_MULT = 1'b1; data_operandA = 32'd6; data_operandB = 32'd7;
    @(negedge clock);
    ctrl_MULT = 1'b0; data_operandA = $urandom; data_operandB = $urandom;
    cnt = 0; at = -1; rdy_res = '0;
    for (int n = 11; n < 80; n++) begin
      if (data_resultRDY) begin
        cnt++; at = n; rdy_res = data_result;
      end
      @(negedge clock);
    end
    chk("restart_cnt", cnt, 1);
    chk("restart_cyc", at, 27);
    chk("restart_res", rdy_res, 32'h0000_002A);

    // Back-to-back: divide started in the DONE cycle of a multiply.
    pulse(1, 0, 32'd3, 32'd5);
    repeat (16) @(negedge clock);
    chk("b2b_rdy17", {31'd0, data_resultRDY}, 32'd1);
    chk("b2b_res17", data_result, 32'd15);
    ctrl_DIV = 1'b1; data_operandA = 32'd100; data_operandB = 32'hFFFF_FFF9;
    @(negedge clock);
    ctrl_DIV = 1'b0; data_operandA = $urandom; data_operandB = $urandom;
    wait_rdy(33, 32'hFFFF_FFF2, 0, "b2b_div");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
